// File: rtl/emu_ctrl_if.sv
// emu_ctrl_if: command/status bundle between the emulation run controller
// (slave side) and whatever drives it (VIO or bench, master side).
interface emu_ctrl_if #(
   parameter int N      = 3,
   parameter int TIME_W = 32,
   parameter int CNT_W  = 32
);
   logic [N-1:0]       cke;
   logic [TIME_W-1:0]  time_curr;
   logic [TIME_W-1:0]  time_stop;
   logic               cmd_run;
   logic               cmd_pause;
   logic               cmd_step;
   logic               rst_core;
   logic [N-1:0]       rst_dom;
   logic               emu_en;
   logic               sim_done;
   logic [2:0]         state;
   logic [N*CNT_W-1:0] evt_cnt;

   modport master (
      output cke, time_curr, time_stop, cmd_run, cmd_pause, cmd_step,
      input  rst_core, rst_dom, emu_en, sim_done, state, evt_cnt
   );

   modport slave (
      input  cke, time_curr, time_stop, cmd_run, cmd_pause, cmd_step,
      output rst_core, rst_dom, emu_en, sim_done, state, evt_cnt
   );
endinterface

// File: rtl/emu_ctrl.sv
// emu_ctrl: emulation run controller. Sequences core/per-domain resets,
// gates emulated-time advance (run/pause/step), stops at a programmable
// time and, when EMU_CTRL_CNT_EN is defined, counts per-domain clock-enable
// events. Without EMU_CTRL_CNT_EN the counters are not built and evt_cnt=0.
module emu_ctrl #(
   parameter int N          = 3,
   parameter int TIME_W     = 32,
   parameter int CNT_W      = 32,
   parameter int RST_CYCLES = 4
) (
   input  logic      clk_sys,
   input  logic      rst,
   emu_ctrl_if.slave bus
);
   localparam logic [2:0] S_RESET = 3'd0;
   localparam logic [2:0] S_ALIGN = 3'd1;
   localparam logic [2:0] S_PAUSE = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_STEP  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   logic [2:0]      state_q, state_d;
   logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
   logic [N-1:0]    rst_dom_q, rst_dom_d;
   logic            rst_core_q, rst_core_d;
   logic            emu_en_q, emu_en_d;
   logic            sim_done_q, sim_done_d;
   logic            stop_q, stop_d;
   logic [N-1:0]    dom_left;

   // Next state; outputs are decoded from the next state so they come out of flops
   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      rst_dom_d = rst_dom_q;
      // registered stop compare: the time manager may advance one extra event
      stop_d    = (bus.time_curr >= bus.time_stop);
      dom_left  = rst_dom_q & ~bus.cke;
      case (state_q)
         S_RESET: begin
            rst_dom_d = '1;
            if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) state_d = S_ALIGN;
            else                                     rst_cnt_d = rst_cnt_q + RC_W'(1);
         end
         S_ALIGN: begin
            // each domain leaves reset on its first enable; last one releases us
            rst_dom_d = dom_left;
            if (dom_left == '0) state_d = S_PAUSE;
         end
         S_PAUSE: begin
            if (bus.cmd_pause)     state_d = S_PAUSE;
            else if (bus.cmd_step) state_d = S_STEP;
            else if (bus.cmd_run)  state_d = S_RUN;
         end
         S_RUN: begin
            if (stop_q)                          state_d = S_DONE;
            else if (bus.cmd_pause || bus.cmd_step) state_d = S_PAUSE;
         end
         S_STEP: begin
            state_d = stop_q ? S_DONE : S_PAUSE;
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d   = S_RESET;
            rst_cnt_d = '0;
            rst_dom_d = '1;
         end
      endcase
      if (rst) begin
         state_d   = S_RESET;
         rst_cnt_d = '0;
         rst_dom_d = '1;
         stop_d    = 1'b0;
      end
      rst_core_d = (state_d == S_RESET);
      emu_en_d   = (state_d == S_ALIGN) || (state_d == S_RUN) || (state_d == S_STEP);
      sim_done_d = (state_d == S_DONE);
   end

   // Control and output registers
   always_ff @(posedge clk_sys) begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      rst_dom_q  <= rst_dom_d;
      rst_core_q <= rst_core_d;
      emu_en_q   <= emu_en_d;
      sim_done_q <= sim_done_d;
      stop_q     <= stop_d;
   end

   assign bus.state    = state_q;
   assign bus.rst_core = rst_core_q;
   assign bus.rst_dom  = rst_dom_q;
   assign bus.emu_en   = emu_en_q;
   assign bus.sim_done = sim_done_q;

`ifdef EMU_CTRL_CNT_EN
   logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic                    cnt_act;

   assign cnt_act = emu_en_q && ((state_q == S_RUN) || (state_q == S_STEP));

   // Per-domain event counters, free-wrapping
   always_comb begin
      for (int i = 0; i < N; i++) begin
         cnt_d[i] = cnt_q[i];
         if (rst)                         cnt_d[i] = '0;
         else if (cnt_act && bus.cke[i])  cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
   end

   // Counter registers
   always_ff @(posedge clk_sys) begin
      cnt_q <= cnt_d;
   end

   // packed [N-1:0][CNT_W-1:0] places domain i at [i*CNT_W +: CNT_W]
   assign bus.evt_cnt = cnt_q;
`else
   assign bus.evt_cnt = '0;
`endif
endmodule

// File: doc/emu_ctrl.md
# emu_ctrl

Parametrised emulation run controller for the link emulator. It replaces the ad-hoc per-domain reset registers and the `sim_done` monitor at the top level with one block. The block covers:
- sequencing of per-domain resets for N emulated clock domains;
- gating of emulated-time advance with run, pause and single-step commands;
- a programmable stop time;
- optional per-domain clock-enable event counters.

It sits beside the time manager in the `clk_sys` domain and is driven from VIO or the bench.

## Interface
Parameters:
- `N`, 3: number of emulated clock domains (TX, RX_P, RX_N by default); legal range 1–16.
- `TIME_W`, 32: width of the emulated-time word.
- `CNT_W`, 32: width of each per-domain event counter.
- `RST_CYCLES`, 4: number of `clk_sys` cycles spent in RESET; minimum 1.

Ports:
- `clk_sys` in 1: system clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous, active-high. Clock is `clk_sys`.
- `cke` in N: clock-enable strobes of the emulated domains, one bit per domain.
- `time_curr` in TIME_W: current emulated time, unsigned.
- `time_stop` in TIME_W: stop time, unsigned. Sampled every cycle.
- `cmd_run` in 1: single-cycle command pulse to run.
- `cmd_pause` in 1: single-cycle command pulse to pause.
- `cmd_step` in 1: single-cycle command pulse to single-step.
- `rst_core` out 1: reset for the time manager, filter and const_clock instances.
- `rst_dom` out N: per-domain reset, one bit per domain.
- `emu_en` out 1: advance enable for the time manager.
- `sim_done` out 1: sticky end-of-simulation flag.
- `state` out 3: FSM state encoding.
- `evt_cnt` out N*CNT_W: per-domain event counters. Domain i occupies bits [i*CNT_W +: CNT_W].

## Operation
- FSM states and encodings: RESET=0, ALIGN=1, PAUSE=2, RUN=3, STEP=4, DONE=5.
- `rst` high: go to RESET and clear all counters and flags.
- RESET:
  - Outputs: `rst_core`=1, `rst_dom`=all 1s, `emu_en`=0.
  - Stays for exactly RST_CYCLES cycles after `rst` falls, then goes to ALIGN.
- ALIGN:
  - `rst_core`=0.
  - Each `rst_dom[i]` clears on the first cycle in which `cke[i]`=1 and then stays 0.
  - When all `rst_dom` bits are 0, go to PAUSE.
  - `emu_en`=1 in ALIGN. This lets the domains produce enables.
- PAUSE:
  - `emu_en`=0.
  - `cmd_step` goes to STEP.
  - `cmd_run` goes to RUN.
- RUN:
  - `emu_en`=1.
  - `cmd_pause` goes to PAUSE.
- STEP:
  - `emu_en`=1 for exactly one cycle, then back to PAUSE.
- DONE:
  - Entered from RUN or STEP when `time_curr` >= `time_stop` (unsigned compare).
  - `emu_en`=0 and `sim_done`=1.
  - Stays until `rst`. Commands are ignored.
- Command priority when pulses are simultaneous: stop condition > `cmd_pause` > `cmd_step` > `cmd_run`.
  - Example: `cmd_run` and `cmd_pause` together in PAUSE leaves the FSM in PAUSE.
  - `cmd_step` in RUN behaves as `cmd_pause`.
- Stop check is skipped in RESET, ALIGN and PAUSE.
  - `time_stop` = 0 therefore enters DONE on the first RUN/STEP cycle.
- Counters: `evt_cnt[i]` increments when `cke[i]`=1 and `emu_en`=1 and the state is RUN or STEP.
  - Counters wrap modulo 2^CNT_W and do not saturate.

## Timing
- All outputs are registered.
- Reset values:
  - `state`=RESET
  - `rst_core`=1
  - `rst_dom`=all 1s
  - `emu_en`=0
  - `sim_done`=0
  - `evt_cnt`=0
- Command latency: a pulse sampled at edge k changes `state` and `emu_en` at edge k+1.
- Stop latency: the compare is registered.
  - `time_curr` >= `time_stop` at edge k gives `sim_done`=1 and `emu_en`=0 after edge k+1.
  - The time manager may therefore advance at most one extra event.
- `rst_dom[i]` release: `cke[i]` sampled high at edge k gives `rst_dom[i]`=0 after edge k.
- `rst` asserted mid-operation: all outputs return to reset values after the next edge, regardless of state.

## Configuration
- `EMU_CTRL_CNT_EN` defined: the event counters are built as described above.
- `EMU_CTRL_CNT_EN` undefined: no counter registers are synthesised and `evt_cnt` is tied to 0. All other behaviour is identical.

## Test plan
- Reset sequence, with N=3, RST_CYCLES=4:
  - Stimulus: release `rst`; pulse `cke`=001, then 010, then 100, one per cycle.
  - Response: `rst_core` falls 4 cycles after `rst`. `rst_dom` steps 111→110→100→000, then `state`=PAUSE.
- Run to stop, with `time_stop`=1000:
  - Stimulus: `cmd_run`; ramp `time_curr` by 100 per cycle.
  - Response: `sim_done`=1 one cycle after `time_curr`=1000. `emu_en`=0 from then on. `state`=DONE holds through `cmd_run` pulses.
- Single step:
  - Stimulus: in PAUSE, pulse `cmd_step` three times, 5 cycles apart, with `cke`=111 held.
  - Response: exactly 3 `emu_en` pulses of 1 cycle each. With `EMU_CTRL_CNT_EN`, each counter = 3.
- Simultaneous commands:
  - Stimulus: `cmd_run` and `cmd_pause` in the same cycle from PAUSE.
  - Response: `state` stays PAUSE and `emu_en`=0.
  - Stimulus: `cmd_step` in RUN.
  - Response: `state`=PAUSE.
- Mid-run reset:
  - Stimulus: assert `rst` while in RUN with counters at 57.
  - Response: next cycle shows `state`=RESET, `evt_cnt`=0, `rst_dom`=111, `emu_en`=0, `sim_done`=0.
- Counter wrap, with CNT_W=4:
  - Stimulus: `cke[0]` held high in RUN for 17 cycles.
  - Response: `evt_cnt[0]`=1.
  - Build without `EMU_CTRL_CNT_EN`: `evt_cnt` stays 0 throughout.
